// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO with sticky overrun/framing flags.
// The line is resynchronized, sampled mid-bit, and each good byte is pushed into a circular buffer.
module uart_rx_fifo #(
    parameter int unsigned clk_freq_hz = 27000000,
    parameter int unsigned baud_rate   = 115200,
    parameter int unsigned fifo_depth  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(fifo_depth):0]   o_count,
    output logic                          o_overrun,
    output logic                          o_frame_err,
    input  logic                          i_clr_err
);

    localparam int unsigned DIV = clk_freq_hz / baud_rate;
    localparam int unsigned BW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(fifo_depth);
    localparam int unsigned PW  = AW + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          push_c;
    logic          ferr_set_c;

    logic [7:0]    mem_q [fifo_depth];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] count_q, count_d;
    logic          valid_q;
    logic          ovr_q, ferr_q;
    logic          full_c, pop_c, wr_en_c, ovr_set_c;

    assign rx_s = sync_q[1];

    // State register, line synchronizer and receive datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= 2'b11;
            state_q  <= IDLE;
            baud_q   <= '0;
            bitcnt_q <= '0;
            sh_q     <= '0;
        end else begin
            sync_q   <= {sync_q[0], i_rx};
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bitcnt_d   = bitcnt_q;
        sh_d       = sh_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    baud_d  = BW'(DIV / 2 - 1);
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        baud_d   = BW'(DIV - 1);
                        bitcnt_d = 3'd0;
                        state_d  = DATA;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    sh_d     = {rx_s, sh_q[7:1]};
                    baud_d   = BW'(DIV - 1);
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (rx_s) begin
                        push_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_d    = WAIT_HIGH;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high so a break yields no bytes
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO control: a pop frees the slot a same-cycle push into a full FIFO reuses
    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c     = valid_q & i_ready;
    assign wr_en_c   = push_c & (~full_c | pop_c);
    assign ovr_set_c = push_c & full_c & ~pop_c;
    assign count_d   = count_q + PW'(wr_en_c) - PW'(pop_c);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
            ovr_q   <= ovr_set_c  | (ovr_q  & ~i_clr_err);
            ferr_q  <= ferr_set_c | (ferr_q & ~i_clr_err);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= sh_q;
    end

    assign o_data      = valid_q ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign o_valid     = valid_q;
    assign o_count     = count_q;
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a show-ahead receive FIFO, the inbound counterpart of the SoC's transmit-only UART emitter. It sits between the board `RXD` pin and the SoC IO page. The SoC reads `o_data` through a new IO data register and pops one byte per read strobe. Status (`o_valid`, `o_count`, sticky error flags) feeds the UART control/status word.

## Interface

Parameters:
- `clk_freq_hz`, 27000000, system clock frequency.
- `baud_rate`, 115200, serial bit rate. Bit period `DIV = clk_freq_hz / baud_rate` (integer division, 234 at defaults). `DIV` must be ≥ 4.
- `fifo_depth`, 16, FIFO entries. Must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk` input 1: system clock, all logic on rising edge.
- `i_rst` input 1: asynchronous active-high reset.
- `i_rx` input 1: serial line, asynchronous to `i_clk`, idle high.
- `o_data` output 8: FIFO head byte; 8'h00 when `o_valid`=0.
- `o_valid` output 1: FIFO non-empty.
- `i_ready` input 1: pop request; a pop occurs when `o_valid & i_ready`.
- `o_count` output $clog2(fifo_depth)+1: bytes held, 0..fifo_depth.
- `o_overrun` output 1: sticky; a received byte was dropped because the FIFO was full.
- `o_frame_err` output 1: sticky; a stop bit sampled low.
- `i_clr_err` input 1: clears both sticky flags.

## Operation

- `i_rx` passes through a 2-FF synchronizer, reset value 1. The FSM sees only the synchronized `rx_s`.
- Bit counter `bitcnt` (3 bit), baud counter `baud` (width $clog2(DIV)), shift register `sh` (8 bit, LSB first).
- State machine, reset state IDLE:
  - **IDLE**: on `rx_s`=0, load `baud`=DIV/2−1 and go to START.
  - **START**: when `baud` reaches 0, resample. If `rx_s`=1 it was a glitch → IDLE. If `rx_s`=0, load `baud`=DIV−1, set `bitcnt`=0, go to DATA.
  - **DATA**: on each `baud`=0, shift `rx_s` into `sh[7]` (right shift) and reload `baud`=DIV−1. After the 8th bit (`bitcnt`=7), go to STOP.
  - **STOP**: on `baud`=0, sample. If 1, push `sh` and go to IDLE. If 0, set `o_frame_err`, discard the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s`=1, then go to IDLE. This prevents a break from generating spurious bytes.
- FIFO: circular buffer, read/write pointers of $clog2(fifo_depth)+1 bits. Full when the pointers differ only in the MSB; empty when they are equal. Pointers wrap modulo 2·fifo_depth.
- Push while full with no pop in the same cycle: byte dropped, `o_overrun` set, FIFO contents unchanged.
- Push and pop in the same cycle: both performed even when full. `o_count` is unchanged and no overrun is raised.
- Pop while empty: ignored; pointers unchanged.
- `i_clr_err` and a same-cycle error event: the set wins (flag remains 1).
- FSM and FIFO are independent. Popping never stalls reception.

## Timing

- Reset values: `o_valid`=0, `o_data`=8'h00, `o_count`=0, `o_overrun`=0, `o_frame_err`=0. FSM in IDLE, synchronizer at 1, pointers at 0.
- `i_rst` asserted mid-frame aborts immediately; the partial byte is lost. After release the receiver waits for a fresh falling edge. A low line at release is treated as a start bit and is rejected by the START recheck or framing logic.
- Input latency: `i_rx` edge to `rx_s` is 2 cycles.
- Sample point: middle of each bit, DIV/2 cycles after the detected start edge, then every DIV cycles.
- Output latency: stop-bit sample cycle to `o_valid`/`o_count` update is 1 cycle (registered push). `o_data` is combinational from the head entry (show-ahead).
- Pop: the cycle after `o_valid & i_ready`, `o_data` shows the next entry, or 8'h00 if the FIFO is now empty.
- Sustained throughput: one byte per 10·DIV cycles. Back-to-back frames are accepted because IDLE re-arms in the cycle after the stop sample.

## Test plan

- **Single byte**: defaults, drive 0xA5 (8N1, 234 cycles/bit) → `o_valid` rises 1 cycle after the stop sample, `o_data`=0xA5, `o_count`=1. Pop with `i_ready`=1 → `o_valid`=0, `o_data`=0x00.
- **Glitch**: drive `i_rx` low for 50 cycles → no byte, FSM back in IDLE, `o_count`=0.
- **Frame error**: drive 0x3C with a low stop bit held low 2000 cycles, then a valid 0x55 → `o_frame_err`=1, only 0x55 in the FIFO. `i_clr_err` → flag 0.
- **Overrun and wrap-around**: send 17 bytes 0x00..0x10 with no pops → `o_count`=16, `o_overrun`=1, 0x10 dropped. Pop all: 0x00..0x0F in order. Then 20 more push/pop cycles → data intact across pointer wrap.
- **Full with simultaneous push/pop**: FIFO full, assert `i_ready` in the push cycle → 17th byte accepted, `o_overrun` stays 0, `o_count` stays 16.
- **Reset mid-frame**: assert `i_rst` during bit 4 of 0xFF → all outputs at reset values. Next 0x81 is received correctly.
